puc_sequencer: RTL

Instruction sequencer for the PucCPU core. It fetches instructions from program memory over a req/ack handshake and decodes each opcode. It drives the ALU's opCode/register1/accumulator inputs and owns the accumulator and program counter. It also owns a small register file that a host preloads while the core is stopped.

---
 rtl/puc_sequencer_pkg.sv | 26 ++
 rtl/puc_sequencer_if.sv | 25 ++
 rtl/puc_regfile.sv | 23 ++
 rtl/puc_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/puc_sequencer_pkg.sv
// Shared constants for the PucCPU sequencer: datapath widths, opcode map and FSM states.
package puc_sequencer_pkg;
  localparam int OPCODE_WIDTH   = 4;
  localparam int REGISTER_WIDTH = 8;
  localparam int REG_ADDR_WIDTH = 2;
  localparam int PC_WIDTH       = 8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_INC   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_LOAD  = 4'd5,
    OP_STORE = 4'd6,
    OP_JZ    = 4'd7,
    OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALTED  = 2'd3
  } state_e;
endpackage

// File: rtl/puc_sequencer_if.sv
// Fetch bus plus ALU operand/result wires between the sequencer and its neighbours.
interface puc_sequencer_if #(
  parameter int OPCODE_WIDTH   = puc_sequencer_pkg::OPCODE_WIDTH,
  parameter int REGISTER_WIDTH = puc_sequencer_pkg::REGISTER_WIDTH,
  parameter int REG_ADDR_WIDTH = puc_sequencer_pkg::REG_ADDR_WIDTH,
  parameter int PC_WIDTH       = puc_sequencer_pkg::PC_WIDTH
);
  logic                                   instrReq;
  logic [PC_WIDTH-1:0]                    instrAddr;
  logic                                   instrAck;
  logic [OPCODE_WIDTH+REG_ADDR_WIDTH-1:0] instrData;
  logic [OPCODE_WIDTH-1:0]                aluOpCode;
  logic [REGISTER_WIDTH-1:0]              aluRegister1;
  logic [REGISTER_WIDTH-1:0]              aluAccumulator;
  logic [REGISTER_WIDTH-1:0]              aluResult;

  modport master (
    output instrReq, instrAddr, aluOpCode, aluRegister1, aluAccumulator,
    input  instrAck, instrData, aluResult
  );
  modport slave (
    input  instrReq, instrAddr, aluOpCode, aluRegister1, aluAccumulator,
    output instrAck, instrData, aluResult
  );
endinterface

// File: rtl/puc_regfile.sv
// Small register file: async clear, one combinational read port, one write port.
module puc_regfile #(
  parameter int NUM_REGS       = 4,
  parameter int REGISTER_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      we_i,
  input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
  input  logic [REGISTER_WIDTH-1:0] wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_i,
  output logic [REGISTER_WIDTH-1:0] rdata_o
);
  logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0] regs_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)   regs_q          <= '0;
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = regs_q[raddr_i];
endmodule

// File: rtl/puc_sequencer.sv
// PucCPU instruction sequencer: fetch over req/ack, one-cycle execute, owns PC/accumulator/regfile.
module puc_sequencer #(
  parameter int OPCODE_WIDTH   = puc_sequencer_pkg::OPCODE_WIDTH,
  parameter int REGISTER_WIDTH = puc_sequencer_pkg::REGISTER_WIDTH,
  parameter int REG_ADDR_WIDTH = puc_sequencer_pkg::REG_ADDR_WIDTH,
  parameter int PC_WIDTH       = puc_sequencer_pkg::PC_WIDTH
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      start,
  puc_sequencer_if.master           bus,
  input  logic                      regWrEn,
  input  logic [REG_ADDR_WIDTH-1:0] regWrAddr,
  input  logic [REGISTER_WIDTH-1:0] regWrData,
  output logic [REGISTER_WIDTH-1:0] accumulator,
  output logic                      busy,
  output logic                      halted
);
  import puc_sequencer_pkg::*;

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam int INSTR_W  = OPCODE_WIDTH + REG_ADDR_WIDTH;

  state_e                    state_q, state_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [REGISTER_WIDTH-1:0] acc_q, acc_d;
  logic [INSTR_W-1:0]        instr_q, instr_d;

  logic [OPCODE_WIDTH-1:0]   op;
  logic [REG_ADDR_WIDTH-1:0] ridx;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [REGISTER_WIDTH-1:0] rf_wdata, rf_rdata;

  assign op   = instr_q[INSTR_W-1 -: OPCODE_WIDTH];
  assign ridx = instr_q[REG_ADDR_WIDTH-1:0];

  puc_regfile #(
    .NUM_REGS      (NUM_REGS),
    .REGISTER_WIDTH(REGISTER_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clock  (clock),
    .resetN (resetN),
    .we_i   (rf_we),
    .waddr_i(rf_waddr),
    .wdata_i(rf_wdata),
    .raddr_i(ridx),
    .rdata_o(rf_rdata)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      instr_q <= instr_d;
    end
  end

  // Host writes and STORE share the single write port; they never overlap in state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    instr_d  = instr_q;
    rf_we    = 1'b0;
    rf_waddr = regWrAddr;
    rf_wdata = regWrData;
    case (state_q)
      S_IDLE, S_HALTED: begin
        rf_we = regWrEn;
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.instrAck) begin
          instr_d = bus.instrData;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_INC, OP_AND, OP_OR: acc_d = bus.aluResult;
          OP_LOAD:  acc_d = rf_rdata;
          OP_STORE: begin
            rf_we    = 1'b1;
            rf_waddr = ridx;
            rf_wdata = acc_q;
          end
          OP_JZ:    if (acc_q == '0) pc_d = PC_WIDTH'(rf_rdata);
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALTED;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instrReq       = (state_q == S_FETCH);
  assign bus.instrAddr      = pc_q;
  assign bus.aluOpCode      = (state_q == S_EXECUTE) ? op : OPCODE_WIDTH'(OP_NOP);
  assign bus.aluRegister1   = rf_rdata;
  assign bus.aluAccumulator = acc_q;
  assign accumulator        = acc_q;
  assign busy               = (state_q == S_FETCH) || (state_q == S_EXECUTE);
  assign halted             = (state_q == S_HALTED);
endmodule
